// File: rtl/regfile16_sweep.sv
// regfile16_sweep: 16 x WIDTH register bank with one synchronous write port,
// two combinational read ports, r0 hardwired to zero, and a clear sequencer
// that sweeps r1..r15 to zero (busy for 15 sweep cycles + 1 done cycle).
// Optional: define REGFILE16_BYPASS_EN for write-to-read forwarding.
//
// state | meaning
// IDLE  | accepting writes and clear requests
// SWEEP | zeroing reg[idx_q] each edge, idx_q runs 1..15
// DONE  | clr_done pulse, returns to IDLE next edge
module regfile16_sweep #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ack,
  input  logic [3:0]       rd_a_sel,
  output logic [WIDTH-1:0] rd_a,
  input  logic [3:0]       rd_b_sel,
  output logic [WIDTH-1:0] rd_b,
  input  logic             clr_req,
  output logic             busy,
  output logic             clr_done
);

  typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic             wr_ack_q;
  logic [WIDTH-1:0] mem_q [16];
  logic             wr_accept;

  assign wr_accept = wr_en && (state_q == IDLE);

  // State and sweep index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 4'd1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic; the index never advances past 15
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          idx_d   = 4'd1;
        end
      end
      SWEEP: begin
        if (idx_q == 4'd15) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = 4'd1;
      end
      default: begin
        state_d = IDLE;
        idx_d   = 4'd1;
      end
    endcase
  end

  // Status outputs decoded from the state register
  always_comb begin
    busy     = (state_q != IDLE);
    clr_done = (state_q == DONE);
  end

  // Write acknowledge: one cycle after the accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack_q <= 1'b0;
    end else begin
      wr_ack_q <= wr_accept;
    end
  end

  assign wr_ack = wr_ack_q;

  // Register storage; entry 0 is never written so it stays zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_accept && (wr_addr != 4'd0)) begin
      mem_q[wr_addr] <= wr_data;
    end else if (state_q == SWEEP) begin
      mem_q[idx_q] <= '0;
    end
  end

  // Combinational read ports with optional forwarding of an accepted write
  always_comb begin
    rd_a = (rd_a_sel == 4'd0) ? '0 : mem_q[rd_a_sel];
    rd_b = (rd_b_sel == 4'd0) ? '0 : mem_q[rd_b_sel];
`ifdef REGFILE16_BYPASS_EN
    if (wr_accept && (wr_addr != 4'd0) && (rd_a_sel == wr_addr)) begin
      rd_a = wr_data;
    end
    if (wr_accept && (wr_addr != 4'd0) && (rd_b_sel == wr_addr)) begin
      rd_b = wr_data;
    end
`else
`endif
  end

endmodule

// File: tb/tb_regfile16_sweep.sv
// Self-checking bench for regfile16_sweep: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// cycle-count based behavioural model.
module tb_regfile16_sweep;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = 4'd0;
  logic [31:0] wr_data = 32'd0;
  logic        wr_ack;
  logic [3:0]  rd_a_sel = 4'd0;
  logic [31:0] rd_a;
  logic [3:0]  rd_b_sel = 4'd0;
  logic [31:0] rd_b;
  logic        clr_req = 1'b0;
  logic        busy;
  logic        clr_done;

  int total = 0;
  int bad = 0;

  regfile16_sweep #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_a_sel(rd_a_sel), .rd_a(rd_a), .rd_b_sel(rd_b_sel), .rd_b(rd_b),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  // Behavioural model: register contents plus number of busy cycles left.
  logic [31:0] m_regs [16];
  int          m_left;
  logic        m_ack;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
      m_left = 0;
      m_ack  = 1'b0;
    end else begin
      m_ack = wr_en && (m_left == 0);
      if (m_left == 0) begin
        if (wr_en && wr_addr != 4'd0) m_regs[wr_addr] = wr_data;
        if (clr_req) m_left = 16;
      end else begin
        // busy cycle k (k = 17 - m_left) clears register k for k = 1..15
        if (m_left >= 2) m_regs[17 - m_left] = 32'd0;
        m_left = m_left - 1;
      end
    end
  end

  function automatic logic [31:0] m_read(input logic [3:0] sel);
    logic [31:0] v;
    v = m_regs[sel];
`ifdef REGFILE16_BYPASS_EN
    if (wr_en && m_left == 0 && wr_addr != 4'd0 && sel == wr_addr) v = wr_data;
`endif
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    chk("model rd_a", rd_a, m_read(rd_a_sel));
    chk("model rd_b", rd_b, m_read(rd_b_sel));
    chk("model busy", {31'd0, busy}, {31'd0, m_left != 0});
    chk("model clr_done", {31'd0, clr_done}, {31'd0, m_left == 1});
    chk("model wr_ack", {31'd0, wr_ack}, {31'd0, m_ack});
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick;
    wr_en = 1'b0;
  endtask

  task automatic start_sweep;
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
  endtask

  task automatic all_zero(input string name);
    for (int i = 0; i < 16; i++) begin
      rd_a_sel = 4'(i);
      rd_b_sel = 4'(15 - i);
      #0.1;
      chk(name, rd_a, 32'd0);
      chk(name, rd_b, 32'd0);
    end
  endtask

  initial begin
    // Reset then idle
    rst_n = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    #1;
    all_zero("reset read");
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset wr_ack", {31'd0, wr_ack}, 32'd0);
    chk("reset clr_done", {31'd0, clr_done}, 32'd0);

    // Basic writes and r0
    wr(4'd5, 32'hDEADBEEF);
    chk("ack r5", {31'd0, wr_ack}, 32'd1);
    wr(4'd10, 32'h12345678);
    chk("ack r10", {31'd0, wr_ack}, 32'd1);
    rd_a_sel = 4'd5; rd_b_sel = 4'd10; #1;
    chk("read r5", rd_a, 32'hDEADBEEF);
    chk("read r10", rd_b, 32'h12345678);
    tick;
    chk("ack drops", {31'd0, wr_ack}, 32'd0);
    wr(4'd0, 32'hFFFFFFFF);
    chk("ack r0", {31'd0, wr_ack}, 32'd1);
    rd_a_sel = 4'd0; #1;
    chk("read r0", rd_a, 32'd0);
    tick;

    // Fill and sweep
    for (int i = 1; i < 16; i++) wr(4'(i), 32'(i * 32'h11));
    rd_a_sel = 4'd15; #1;
    chk("fill r15", rd_a, 32'h000000FF);
    start_sweep;
    for (int k = 1; k <= 16; k++) begin
      chk("sweep busy", {31'd0, busy}, 32'd1);
      chk("sweep clr_done", {31'd0, clr_done}, {31'd0, k == 16});
      tick;
    end
    chk("sweep end busy", {31'd0, busy}, 32'd0);
    all_zero("after sweep");

    // Write held through a sweep
    start_sweep;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hA5A5A5A5;
    for (int k = 1; k <= 16; k++) begin
      chk("held no ack", {31'd0, wr_ack}, 32'd0);
      tick;
    end
    chk("held idle no ack yet", {31'd0, wr_ack}, 32'd0);
    tick;
    chk("held ack", {31'd0, wr_ack}, 32'd1);
    wr_en = 1'b0;
    rd_a_sel = 4'd3; #1;
    chk("held r3", rd_a, 32'hA5A5A5A5);
    tick;

    // Reset mid-sweep
    for (int i = 9; i < 16; i++) wr(4'(i), 32'hC0DE0000 + 32'(i));
    start_sweep;
    for (int k = 1; k < 7; k++) tick;
    rd_a_sel = 4'd12; #1;
    chk("pre-abort r12", rd_a, 32'hC0DE000C);
    rst_n = 1'b0;
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort clr_done", {31'd0, clr_done}, 32'd0);
    all_zero("abort read");
    tick;
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk("abort no done", {31'd0, clr_done}, 32'd0);
      tick;
    end

    // Forwarding behaviour
    wr(4'd7, 32'h11111111);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h0BADF00D; rd_a_sel = 4'd7;
    #1;
`ifdef REGFILE16_BYPASS_EN
    chk("bypass same cycle", rd_a, 32'h0BADF00D);
`else
    chk("no bypass old", rd_a, 32'h11111111);
`endif
    tick;
    wr_en = 1'b0;
    #1;
    chk("r7 after edge", rd_a, 32'h0BADF00D);
    tick;

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      wr_en    = ($urandom_range(0, 2) != 0);
      wr_addr  = 4'($urandom_range(0, 15));
      wr_data  = $urandom;
      clr_req  = ($urandom_range(0, 19) == 0);
      rd_a_sel = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      rd_b_sel = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
      end else begin
        tick;
      end
    end
    wr_en = 1'b0; clr_req = 1'b0;
    tick; tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
